// File: rtl/frame_buffer_controller.sv
// Arbiter/controller for the 80x30 character frame buffer RAM: shares the write
// port between host writes and a clear sweep, and the read port between display and host.
module frame_buffer_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2400
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Host_Wr_Req,
  input  logic [ADDR_WIDTH-1:0] i_Host_Wr_Addr,
  input  logic [DATA_WIDTH-1:0] i_Host_Wr_Data,
  output logic                  o_Host_Wr_Ack,
  input  logic                  i_Host_Rd_Req,
  input  logic [ADDR_WIDTH-1:0] i_Host_Rd_Addr,
  output logic                  o_Host_Rd_Valid,
  output logic [DATA_WIDTH-1:0] o_Host_Rd_Data,
  input  logic                  i_Clear_Start,
  input  logic [DATA_WIDTH-1:0] i_Clear_Value,
  output logic                  o_Clear_Busy,
  output logic                  o_Clear_Done,
  input  logic                  i_Disp_Active,
  input  logic [ADDR_WIDTH-1:0] i_Disp_Rd_Addr,
  output logic [DATA_WIDTH-1:0] o_Disp_Rd_Data,
  output logic                  o_Ram_Wr_En,
  output logic [ADDR_WIDTH-1:0] o_Ram_Wr_Addr,
  output logic [DATA_WIDTH-1:0] o_Ram_Wr_Data,
  output logic [ADDR_WIDTH-1:0] o_Ram_Rd_Addr,
  input  logic [DATA_WIDTH-1:0] i_Ram_Rd_Data
);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_CLEAR} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_CAP}  rd_state_t;

  localparam logic [ADDR_WIDTH:0] LIMIT   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  // ---------------- write side ----------------
  wr_state_t             wr_state, wr_state_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] clr_val_q, clr_val_d;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      wr_state  <= W_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_cnt_q <= '0;
      clr_val_q <= '0;
    end else begin
      wr_state  <= wr_state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clr_cnt_q <= clr_cnt_d;
      clr_val_q <= clr_val_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clr_cnt_d  = clr_cnt_q;
    clr_val_d  = clr_val_q;
    case (wr_state)
      W_IDLE: begin
        if (i_Clear_Start) begin
          // Cell 0 is issued on the accepting edge so busy and write-enable
          // cover exactly the same DEPTH cycles.
          clr_val_d  = i_Clear_Value;
          wr_en_d    = 1'b1;
          wr_addr_d  = '0;
          wr_data_d  = i_Clear_Value;
          clr_cnt_d  = CNT_ONE;
          busy_d     = 1'b1;
          wr_state_d = W_CLEAR;
        end else if (i_Host_Wr_Req) begin
          ack_d      = 1'b1;
          wr_en_d    = in_range(i_Host_Wr_Addr);
          wr_addr_d  = i_Host_Wr_Addr;
          wr_data_d  = i_Host_Wr_Data;
          wr_state_d = W_ACK;
        end
      end
      W_ACK: wr_state_d = W_IDLE;
      W_CLEAR: begin
        if (clr_cnt_q < LIMIT) begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q[ADDR_WIDTH-1:0];
          wr_data_d = clr_val_q;
          clr_cnt_d = clr_cnt_q + CNT_ONE;
        end else begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          clr_cnt_d  = '0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign o_Ram_Wr_En   = wr_en_q;
  assign o_Ram_Wr_Addr = wr_addr_q;
  assign o_Ram_Wr_Data = wr_data_q;
  assign o_Host_Wr_Ack = ack_q;
  assign o_Clear_Busy  = busy_q;
  assign o_Clear_Done  = done_q;

  // ---------------- read side ----------------
  rd_state_t             rd_state, rd_state_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  host_oor_q, host_oor_d;
  logic                  disp_ok_q;
  logic                  host_accept;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;

  assign host_accept = (rd_state == R_IDLE) && i_Host_Rd_Req && !i_Disp_Active;

  always_comb begin
    ram_rd_addr = '0;
    if (i_Disp_Active) begin
      if (in_range(i_Disp_Rd_Addr)) ram_rd_addr = i_Disp_Rd_Addr;
    end else if (host_accept) begin
      if (in_range(i_Host_Rd_Addr)) ram_rd_addr = i_Host_Rd_Addr;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      rd_state   <= R_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      host_oor_q <= 1'b0;
      disp_ok_q  <= 1'b0;
    end else begin
      rd_state   <= rd_state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      host_oor_q <= host_oor_d;
      disp_ok_q  <= i_Disp_Active && in_range(i_Disp_Rd_Addr);
    end
  end

  always_comb begin
    rd_state_d = rd_state;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    host_oor_d = host_oor_q;
    case (rd_state)
      R_IDLE: begin
        if (host_accept) begin
          host_oor_d = !in_range(i_Host_Rd_Addr);
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rd_data_d  = host_oor_q ? '0 : i_Ram_Rd_Data;
        rd_valid_d = 1'b1;
        rd_state_d = R_CAP;
      end
      R_CAP:   rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign o_Ram_Rd_Addr   = ram_rd_addr;
  assign o_Host_Rd_Valid = rd_valid_q;
  assign o_Host_Rd_Data  = rd_data_q;
  assign o_Disp_Rd_Data  = disp_ok_q ? i_Ram_Rd_Data : '0;

endmodule

// File: tb/tb_frame_buffer_controller.sv
// Self-checking bench for frame_buffer_controller: RAM model, write/read
// scoreboards, display vector table and multi-cycle clear/reset sequences.
module tb_frame_buffer_controller;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 2400;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          wr_req, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          clr_start, clr_busy, clr_done;
  logic [DW-1:0] clr_value;
  logic          disp_active;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  frame_buffer_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l),
    .i_Host_Wr_Req(wr_req), .i_Host_Wr_Addr(wr_addr), .i_Host_Wr_Data(wr_data),
    .o_Host_Wr_Ack(wr_ack),
    .i_Host_Rd_Req(rd_req), .i_Host_Rd_Addr(rd_addr),
    .o_Host_Rd_Valid(rd_valid), .o_Host_Rd_Data(rd_data),
    .i_Clear_Start(clr_start), .i_Clear_Value(clr_value),
    .o_Clear_Busy(clr_busy), .o_Clear_Done(clr_done),
    .i_Disp_Active(disp_active), .i_Disp_Rd_Addr(disp_addr), .o_Disp_Rd_Data(disp_data),
    .o_Ram_Wr_En(ram_we), .o_Ram_Wr_Addr(ram_waddr), .o_Ram_Wr_Data(ram_wdata),
    .o_Ram_Rd_Addr(ram_raddr), .i_Ram_Rd_Data(ram_rdata)
  );

  // Dual-port RAM model with one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wq[$];
  logic [DW-1:0] rq[$];

  // Write scoreboard: every RAM write must match the next expected one
  always @(negedge clk) begin
    if (ram_we) begin
      if (wq.size() == 0) begin
        check("unexpected_ram_write", {20'd0, ram_waddr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check("ram_wr_addr", {20'd0, ram_waddr}, {20'd0, e.a});
        check("ram_wr_data", {24'd0, ram_wdata}, {24'd0, e.d});
      end
    end
  end

  // Read scoreboard for host read-back
  always @(negedge clk) begin
    if (rd_valid) begin
      if (rq.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        logic [DW-1:0] e;
        e = rq.pop_front();
        check("host_rd_data", {24'd0, rd_data}, {24'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    wq.push_back('{a: a, d: d});
    tick();
    check("host_write_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    tick();
  endtask

  task automatic push_clear(input int n, input logic [DW-1:0] v);
    for (int i = 0; i < n; i++) wq.push_back('{a: AW'(i), d: v});
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          active;
    logic [AW-1:0] exp_ram_addr;
    logic [DW-1:0] exp_data;
  } disp_vec_t;

  initial begin
    disp_vec_t dv[10];
    int  busy_cycles;
    int  lat;
    bit  ack_seen, done_seen, hit;

    dv[0] = '{addr: 12'd0,    active: 1'b1, exp_ram_addr: 12'd0,    exp_data: 8'h20};
    dv[1] = '{addr: 12'd1,    active: 1'b1, exp_ram_addr: 12'd1,    exp_data: 8'h12};
    dv[2] = '{addr: 12'd2,    active: 1'b1, exp_ram_addr: 12'd2,    exp_data: 8'h20};
    dv[3] = '{addr: 12'd3,    active: 1'b1, exp_ram_addr: 12'd3,    exp_data: 8'h20};
    dv[4] = '{addr: 12'd4,    active: 1'b1, exp_ram_addr: 12'd4,    exp_data: 8'h20};
    dv[5] = '{addr: 12'd2500, active: 1'b1, exp_ram_addr: 12'd0,    exp_data: 8'h00};
    dv[6] = '{addr: 12'd5,    active: 1'b1, exp_ram_addr: 12'd5,    exp_data: 8'h41};
    dv[7] = '{addr: 12'd5,    active: 1'b0, exp_ram_addr: 12'd0,    exp_data: 8'h00};
    dv[8] = '{addr: 12'd2399, active: 1'b1, exp_ram_addr: 12'd2399, exp_data: 8'h20};
    dv[9] = '{addr: 12'd2400, active: 1'b1, exp_ram_addr: 12'd0,    exp_data: 8'h00};

    rst_l = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; clr_start = 1'b0; clr_value = '0;
    disp_active = 1'b0; disp_addr = '0;
    repeat (3) tick();

    // Reset state
    check("rst_wr_en",   {31'd0, ram_we},    32'd0);
    check("rst_wr_addr", {20'd0, ram_waddr}, 32'd0);
    check("rst_wr_data", {24'd0, ram_wdata}, 32'd0);
    check("rst_wr_ack",  {31'd0, wr_ack},    32'd0);
    check("rst_rd_valid",{31'd0, rd_valid},  32'd0);
    check("rst_rd_data", {24'd0, rd_data},   32'd0);
    check("rst_busy",    {31'd0, clr_busy},  32'd0);
    check("rst_done",    {31'd0, clr_done},  32'd0);
    check("rst_disp",    {24'd0, disp_data}, 32'd0);
    rst_l = 1'b1;
    tick();

    // Host write held through W_ACK -> exactly one write
    wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h41;
    wq.push_back('{a: 12'd5, d: 8'h41});
    tick();
    check("wr5_ack",   {31'd0, wr_ack}, 32'd1);
    check("wr5_we",    {31'd0, ram_we}, 32'd1);
    tick();
    check("wr5_ack_w_ack", {31'd0, wr_ack}, 32'd0);
    check("wr5_we_w_ack",  {31'd0, ram_we}, 32'd0);
    wr_req = 1'b0;
    tick();

    // Out-of-range host write: ack only
    wr_req = 1'b1; wr_addr = 12'd2400; wr_data = 8'h55;
    tick();
    check("oor_wr_ack", {31'd0, wr_ack}, 32'd1);
    check("oor_wr_we",  {31'd0, ram_we}, 32'd0);
    wr_req = 1'b0;
    tick();
    check("oor_wr_ack_drop", {31'd0, wr_ack}, 32'd0);

    // Clear with a simultaneous host write: clear wins, host waits for done
    clr_start = 1'b1; clr_value = 8'h20;
    wr_req = 1'b1; wr_addr = 12'd7; wr_data = 8'h99;
    push_clear(DEPTH, 8'h20);
    wq.push_back('{a: 12'd7, d: 8'h99});
    tick();
    clr_start = 1'b0;
    busy_cycles = 0; ack_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!clr_busy) break;
      busy_cycles++;
      if (wr_ack || clr_done) ack_seen = 1'b1;
      tick();
    end
    check("clear_busy_cycles", busy_cycles, DEPTH);
    check("no_ack_or_done_while_busy", {31'd0, ack_seen}, 32'd0);
    check("clear_done_pulse", {31'd0, clr_done}, 32'd1);
    check("no_ack_in_done_cycle", {31'd0, wr_ack}, 32'd0);
    tick();
    check("host_ack_after_clear", {31'd0, wr_ack}, 32'd1);
    check("done_one_cycle", {31'd0, clr_done}, 32'd0);
    wr_req = 1'b0;
    tick();

    // Reset in the middle of a clear sweep
    clr_start = 1'b1; clr_value = 8'h33;
    push_clear(1001, 8'h33);
    tick();
    clr_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (ram_we && ram_waddr == 12'd1000) begin hit = 1'b1; break; end
      tick();
    end
    check("reach_addr_1000", {31'd0, hit}, 32'd1);
    rst_l = 1'b0;
    tick();
    check("midrst_we",   {31'd0, ram_we},   32'd0);
    check("midrst_busy", {31'd0, clr_busy}, 32'd0);
    check("midrst_done", {31'd0, clr_done}, 32'd0);
    rst_l = 1'b1;
    done_seen = 1'b0;
    repeat (3) begin tick(); if (clr_done || clr_busy) done_seen = 1'b1; end
    check("midrst_no_done_after", {31'd0, done_seen}, 32'd0);

    // Fresh clear restarts from address 0 (scoreboard checks order)
    clr_start = 1'b1; clr_value = 8'h20;
    push_clear(DEPTH, 8'h20);
    tick();
    clr_start = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (clr_done) begin done_seen = 1'b1; break; end
      tick();
    end
    check("restart_clear_done", {31'd0, done_seen}, 32'd1);
    tick();
    host_write(12'd5, 8'h41);
    host_write(12'd1, 8'h12);

    // Host read blocked while display active
    disp_active = 1'b1; disp_addr = 12'd2;
    rd_req = 1'b1; rd_addr = 12'd5;
    rq.push_back(8'h41);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("blocked_rd_addr_is_disp", {20'd0, ram_raddr}, 32'd2);
      tick();
      check("blocked_no_valid", {31'd0, rd_valid}, 32'd0);
    end
    disp_active = 1'b0;
    #1;
    check("accept_rd_addr", {20'd0, ram_raddr}, 32'd5);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); lat++;
      if (rd_valid) break;
    end
    check("host_rd_latency", lat, 2);
    rd_req = 1'b0;
    tick();
    check("rd_valid_one_cycle", {31'd0, rd_valid}, 32'd0);
    check("rd_data_held", {24'd0, rd_data}, 32'h41);

    // Out-of-range host read returns zero
    rd_req = 1'b1; rd_addr = 12'd3000;
    rq.push_back(8'h00);
    #1;
    check("oor_rd_addr_masked", {20'd0, ram_raddr}, 32'd0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); lat++;
      if (rd_valid) break;
    end
    check("oor_rd_latency", lat, 2);
    rd_req = 1'b0;
    tick();

    // Display read vector table
    foreach (dv[i]) begin
      disp_addr = dv[i].addr; disp_active = dv[i].active;
      #1;
      check($sformatf("disp_ram_addr[%0d]", i), {20'd0, ram_raddr}, {20'd0, dv[i].exp_ram_addr});
      tick();
      check($sformatf("disp_data[%0d]", i), {24'd0, disp_data}, {24'd0, dv[i].exp_data});
    end
    disp_active = 1'b0;
    repeat (3) tick();

    check("wr_scoreboard_empty", wq.size(), 0);
    check("rd_scoreboard_empty", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
